// File: rtl/mux_pipe_if.sv
// Handshake bundle for mux_pipe: packed select inputs upstream, flow-controlled word downstream.
// The slave modport is the stage itself; the master modport is the surrounding datapath.
interface mux_pipe_if #(
    parameter int unsigned DATA_SIZE = 32,
    parameter int unsigned NUM_IN    = 4
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [NUM_IN*DATA_SIZE-1:0] data_in;
    logic [SEL_W-1:0]            sel;
    logic                        in_valid;
    logic                        in_ready;
    logic                        flush;
    logic [DATA_SIZE-1:0]        data_out;
    logic                        out_valid;
    logic                        out_ready;
    logic [1:0]                  count;
    logic                        sel_err;
    logic                        sel_err_clr;

    modport slave (
        input  data_in,
        input  sel,
        input  in_valid,
        output in_ready,
        input  flush,
        output data_out,
        output out_valid,
        input  out_ready,
        output count,
        output sel_err,
        input  sel_err_clr
    );

    modport master (
        output data_in,
        output sel,
        output in_valid,
        input  in_ready,
        output flush,
        input  data_out,
        input  out_valid,
        output out_ready,
        input  count,
        input  sel_err,
        output sel_err_clr
    );
endinterface

// File: rtl/mux_pipe.sv
// N:1 select stage with a registered valid/ready output backed by a two-entry skid buffer,
// so upstream sees a registered in_ready while the stage still sustains one word per cycle.
module mux_pipe #(
    parameter int unsigned         DATA_SIZE   = 32,
    parameter int unsigned         NUM_IN      = 4,
    parameter logic [DATA_SIZE-1:0] DEFAULT_VAL = '0
) (
    input logic       clk,
    input logic       rst_n,
    mux_pipe_if.slave bus
);
    localparam int unsigned SEL_W = $clog2(NUM_IN);

    logic [DATA_SIZE-1:0] sel_word;
    logic                 sel_oob;
    logic                 accept;
    logic                 pop;

    logic [DATA_SIZE-1:0] main_q, main_d;
    logic                 main_vld_q, main_vld_d;
    logic [DATA_SIZE-1:0] skid_q, skid_d;
    logic                 skid_vld_q, skid_vld_d;
    logic                 in_ready_q, in_ready_d;
    logic                 sel_err_q, sel_err_d;

    // Unmatched codes fall through to the default word and flag the error.
    always_comb begin
        sel_word = DEFAULT_VAL;
        sel_oob  = 1'b1;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (bus.sel == SEL_W'(i)) begin
                sel_word = bus.data_in[i*DATA_SIZE +: DATA_SIZE];
                sel_oob  = 1'b0;
            end
        end
    end

    assign accept = bus.in_valid && in_ready_q;
    assign pop    = main_vld_q && bus.out_ready;

    always_comb begin
        main_d     = main_q;
        main_vld_d = main_vld_q;
        skid_d     = skid_q;
        skid_vld_d = skid_vld_q;

        if (bus.flush) begin
            main_d     = '0;
            main_vld_d = 1'b0;
            skid_vld_d = 1'b0;
        end else if (pop && skid_vld_q) begin
            // in_ready_q is low here, so no accept can collide with the refill.
            main_d     = skid_q;
            skid_vld_d = 1'b0;
        end else begin
            if (pop) begin
                main_d     = '0;
                main_vld_d = 1'b0;
            end
            if (accept) begin
                if (!main_vld_q || pop) begin
                    main_d     = sel_word;
                    main_vld_d = 1'b1;
                end else begin
                    skid_d     = sel_word;
                    skid_vld_d = 1'b1;
                end
            end
        end
    end

    assign in_ready_d = !skid_vld_d;

    always_comb begin
        sel_err_d = sel_err_q;
        if (bus.sel_err_clr) begin
            sel_err_d = 1'b0;
        end
        if (accept && sel_oob) begin
            sel_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q     <= '0;
            main_vld_q <= 1'b0;
            skid_q     <= '0;
            skid_vld_q <= 1'b0;
            in_ready_q <= 1'b1;
            sel_err_q  <= 1'b0;
        end else begin
            main_q     <= main_d;
            main_vld_q <= main_vld_d;
            skid_q     <= skid_d;
            skid_vld_q <= skid_vld_d;
            in_ready_q <= in_ready_d;
            sel_err_q  <= sel_err_d;
        end
    end

    assign bus.data_out  = main_q;
    assign bus.out_valid = main_vld_q;
    assign bus.in_ready  = in_ready_q;
    assign bus.sel_err   = sel_err_q;
    assign bus.count     = {1'b0, main_vld_q} + {1'b0, skid_vld_q};

endmodule

// File: doc/mux_pipe.md
# mux_pipe

Parametrised N:1 select stage with a registered, flow-controlled output, for use at pipeline-register boundaries in the MIPS datapath (forwarding and writeback selection where a stall must not lose data). It selects one of `NUM_IN` packed input words and hands it downstream through a valid/ready handshake. A two-entry skid buffer gives full throughput with a registered `in_ready`. Out-of-range select codes substitute a default value and raise a sticky error flag.

## Interface
- `DATA_SIZE`, 32: width of each data word.
- `NUM_IN`, 4: number of inputs; legal range 2..16.
- `SEL_W`, `$clog2(NUM_IN)`: select width; derived, never overridden.
- `DEFAULT_VAL`, 0: word substituted when `sel >= NUM_IN`.

Ports:
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: reset, asynchronous and active-low.
- `data_in` input `NUM_IN*DATA_SIZE`: packed inputs; input i occupies `[i*DATA_SIZE +: DATA_SIZE]`.
- `sel` input `SEL_W`: selects the input captured on an accepted transfer.
- `in_valid` input 1: upstream offers a transfer.
- `in_ready` output 1: the stage can accept; driven from a register.
- `flush` input 1: synchronous discard of all held words.
- `data_out` output `DATA_SIZE`: head word.
- `out_valid` output 1: `data_out` is valid.
- `out_ready` input 1: downstream accepts the head word.
- `count` output 2: occupancy, 0..2.
- `sel_err` output 1: sticky out-of-range select flag.
- `sel_err_clr` input 1: clears `sel_err`.

## Operation
- Transfer rules:
  - Accept = `in_valid && in_ready`.
  - Pop = `out_valid && out_ready`.
- Accepted word = `data_in[sel]`, or `DEFAULT_VAL` if `sel >= NUM_IN`.
- Storage is a main register (drives `data_out` and `out_valid`) plus a skid register.
- On accept, the captured word goes to:
  - main, if main is empty, or is being popped in the same cycle with skid empty;
  - skid, otherwise.
- On a pop with skid full, skid moves to main in the same edge. An accept in that same cycle is impossible, because `in_ready` is 0 whenever skid is full.
- `in_ready` = skid empty, taken from the registered state. It falls on the edge that fills skid and rises on the edge that empties it.
- `count` = main valid + skid valid. Order is strictly FIFO.
- Flush:
  - Clears main and skid valid on the next edge and overrides any accept or pop in that cycle.
  - Any word offered in the flush cycle is dropped.
  - `data_out` returns to 0.
  - `sel_err` is unaffected.
- `sel_err`:
  - Set on an accept with `sel >= NUM_IN`.
  - Cleared by `sel_err_clr`; set wins over clear in the same cycle.
  - It is never set when `NUM_IN` is a power of two.
- `data_out` is 0 whenever `out_valid` = 0.
- `data_out` holds stable while `out_valid && !out_ready`.
- `sel` and `data_in` are sampled only on accept; they are don't-care otherwise.

## Timing
Reset values (asserted asynchronously, released synchronously):

| Output | Reset value |
|---|---|
| `out_valid` | 0 |
| `data_out` | 0 |
| `count` | 0 |
| `sel_err` | 0 |
| `in_ready` | 1 (skid empty) |

While `rst_n` is low, no accept or pop updates state. Reset in mid-operation discards all words.

Latency and throughput:
- Latency is 1 cycle: a word accepted at edge k is on `data_out` with `out_valid` = 1 after edge k.
- Throughput is 1 word/cycle with `out_ready` held high; skid stays empty.
- Downstream stall: at most 2 words are held. `in_ready` drops the edge after the second word is captured. Upstream must hold `in_valid` and data until `in_ready` = 1.
- No combinational path runs from `out_ready` to `in_ready`. The paths `data_in`/`sel` → registers are combinational through the selector only.

## Test plan
- **Reset:**
  - Stimulus: assert `rst_n` = 0 mid-stream while `count` = 2.
  - Response: `out_valid` = 0, `data_out` = 0, `count` = 0 and `in_ready` = 1 immediately, without waiting for a clock edge.
- **Select sweep:**
  - Stimulus: `NUM_IN` = 4, inputs 0x11111111, 0x22222222, 0x33333333, 0x44444444, `sel` 0..3 on consecutive cycles, `out_ready` = 1.
  - Response: `data_out` shows the same sequence one cycle later, `count` ≤ 1, `in_ready` stays 1.
- **Back-pressure:**
  - Stimulus: push A, B, C with `out_ready` = 0.
  - Response:
    - `count` goes 1 then 2, and `in_ready` = 0 after B is captured.
    - C is held off until `out_ready` = 1.
    - The output order is A, B, C with nothing lost or duplicated.
- **Flush:**
  - Stimulus: `count` = 2, assert `flush` together with `in_valid` and `out_ready`.
  - Response: next cycle `count` = 0, `out_valid` = 0, `in_ready` = 1, and the offered word never appears on the output.
- **Out-of-range:**
  - Stimulus: `NUM_IN` = 3, `DEFAULT_VAL` = 0xDEADBEEF, accept with `sel` = 3.
  - Response: `data_out` = 0xDEADBEEF and `sel_err` = 1.
  - Follow-up: assert `sel_err_clr` alone and `sel_err` = 0. Assert `sel_err_clr` during an accept with `sel` = 3 and `sel_err` stays 1.
- **Random soak:**
  - Stimulus: random `in_valid`/`out_ready`/`sel`, `NUM_IN` = 5, 10k cycles.
  - Response: the scoreboard matches in-order data, and `count` never exceeds 2.
